// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath.
// master = FSM side, slave = datapath side.
interface multicycle_main_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUop;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output ALUop, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
        output AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ALUop, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
        input  AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Optional MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_main_fsm_if.master bus,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     cur, nxt;
    logic [1:0] alu_op, src_a, src_b, res_src;
    logic       adr_src, ir_wr, reg_wr, mem_wr;
    logic       pc_upd, branch, ill;
    logic       mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt     = S_FETCH;
        alu_op  = 2'b00;
        src_a   = 2'b00;
        src_b   = 2'b00;
        res_src = 2'b00;
        adr_src = 1'b0;
        ir_wr   = 1'b0;
        reg_wr  = 1'b0;
        mem_wr  = 1'b0;
        pc_upd  = 1'b0;
        branch  = 1'b0;
        ill     = 1'b0;
        unique case (cur)
            S_FETCH: begin
                src_b   = 2'b10;
                res_src = 2'b10;
                ir_wr   = mem_ok;
                pc_upd  = mem_ok;
                nxt     = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                unique case (bus.opcode)
                    7'b0000011,
                    7'b0100011: nxt = S_MEMADR;
                    7'b0110011: nxt = S_EXECR;
                    7'b0010011: nxt = S_EXECI;
                    7'b1100011: nxt = S_BEQ;
                    7'b1101111: nxt = S_JAL;
                    default: begin
                        nxt = S_FETCH;
                        ill = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a = 2'b10;
                src_b = 2'b01;
                nxt   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                nxt     = mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                res_src = 2'b01;
                reg_wr  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_wr  = 1'b1;
                nxt     = mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                src_a  = 2'b10;
                alu_op = 2'b10;
                nxt    = S_ALUWB;
            end
            S_EXECI: begin
                src_a  = 2'b10;
                src_b  = 2'b01;
                alu_op = 2'b10;
                nxt    = S_ALUWB;
            end
            S_ALUWB: reg_wr = 1'b1;
            S_BEQ: begin
                src_a  = 2'b10;
                alu_op = 2'b01;
                branch = 1'b1;
            end
            S_JAL: begin
                src_a  = 2'b01;
                src_b  = 2'b10;
                pc_upd = 1'b1;
                nxt    = S_ALUWB;
            end
            default: nxt = S_FETCH;
        endcase
        // Reset overrides everything so an abandoned instruction never writes.
        if (!rst_n) begin
            alu_op  = 2'b00;
            src_a   = 2'b00;
            src_b   = 2'b10;
            res_src = 2'b10;
            adr_src = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            mem_wr  = 1'b0;
            pc_upd  = 1'b0;
            branch  = 1'b0;
            ill     = 1'b0;
        end
    end

    always_comb begin
        unique case (bus.opcode)
            7'b0100011: bus.ImmSrc = 2'b01;
            7'b1100011: bus.ImmSrc = 2'b10;
            7'b1101111: bus.ImmSrc = 2'b11;
            default:    bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.ALUop     = alu_op;
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.ResultSrc = res_src;
    assign bus.AdrSrc    = adr_src;
    assign bus.IRWrite   = ir_wr;
    assign bus.RegWrite  = reg_wr;
    assign bus.MemWrite  = mem_wr;
    assign bus.PCWrite   = pc_upd | (branch & bus.zero);
    assign bus.illegal   = ill;
    assign state         = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: state sequences, enables, reset.
// Build with +define+MEM_WAIT_EN to exercise memory wait states.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] state;
    int         checks;
    int         errors;

    multicycle_main_fsm_if bus();

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 7'b0110011;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_enables got=%b exp=00000",
                {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal});
        end
        checks++;
        if ({bus.ALUSrcB, bus.ResultSrc} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_selects got=%b exp=1010", {bus.ALUSrcB, bus.ResultSrc});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.IRWrite, bus.PCWrite, bus.AdrSrc} !== 3'b110) begin
            errors++;
            $display("FAIL fetch_outputs got=%b exp=110",
                {bus.IRWrite, bus.PCWrite, bus.AdrSrc});
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        bus.opcode = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_s[i]) begin
                errors++;
                $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]);
            end
            if (i == 2) begin
                checks++;
                if (bus.ALUop !== 2'b10) begin
                    errors++;
                    $display("FAIL rtype_aluop got=%b exp=10", bus.ALUop);
                end
                // IR change outside DECODE/MEMADR must not redirect the FSM
                bus.opcode = 7'b1111111;
            end
            checks++;
            if (bus.RegWrite !== (i == 3)) begin
                errors++;
                $display("FAIL rtype_regwrite[%0d] got=%b exp=%b", i, bus.RegWrite, i == 3);
            end
            cyc();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL rtype_end got=%0d exp=0", state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        bus.opcode = 7'b0000011;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_s[i]) begin
                errors++;
                $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]);
            end
            checks++;
            if (bus.MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL lw_memwrite[%0d] got=%b exp=0", i, bus.MemWrite);
            end
            if (i == 3) begin
                checks++;
                if (bus.AdrSrc !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_adrsrc got=%b exp=1", bus.AdrSrc);
                end
            end
            if (i == 4) begin
                checks++;
                if ({bus.ResultSrc, bus.RegWrite} !== 3'b011) begin
                    errors++;
                    $display("FAIL lw_wb got=%b exp=011", {bus.ResultSrc, bus.RegWrite});
                end
            end
            cyc();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL lw_end got=%0d exp=0", state);
        end
    endtask

    task automatic test_beq(input logic z);
        bus.opcode = 7'b1100011;
        bus.zero = ~z;
        #1;
        checks++;
        if (bus.ImmSrc !== 2'b10) begin
            errors++;
            $display("FAIL beq_immsrc got=%b exp=10", bus.ImmSrc);
        end
        cyc();
        cyc();
        checks++;
        if (state !== 4'd9) begin
            errors++;
            $display("FAIL beq_state got=%0d exp=9", state);
        end
        checks++;
        if (bus.PCWrite !== ~z) begin
            errors++;
            $display("FAIL beq_pcwrite_pre got=%b exp=%b", bus.PCWrite, ~z);
        end
        bus.zero = z;
        #1;
        checks++;
        if ({bus.PCWrite, bus.ALUop} !== {z, 2'b01}) begin
            errors++;
            $display("FAIL beq_pcwrite z=%b got=%b exp=%b", z,
                {bus.PCWrite, bus.ALUop}, {z, 2'b01});
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL beq_end got=%0d exp=0", state);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        bus.opcode = 7'b1111111;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== ((i == 1) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL ill_state[%0d] got=%0d", i, state);
            end
            checks++;
            if (bus.illegal !== (i == 1)) begin
                errors++;
                $display("FAIL ill_pulse[%0d] got=%b exp=%b", i, bus.illegal, i == 1);
            end
            checks++;
            if ({bus.RegWrite, bus.MemWrite} !== 2'b00) begin
                errors++;
                $display("FAIL ill_writes[%0d] got=%b exp=00", i, {bus.RegWrite, bus.MemWrite});
            end
            if (bus.illegal === 1'b1) pulses++;
            if (i < 2) cyc();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ill_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_itype_jal();
        logic [3:0] exp_i [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        logic [3:0] exp_j [4] = '{4'd0, 4'd1, 4'd10, 4'd8};
        bus.opcode = 7'b0010011;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_i[i]) begin
                errors++;
                $display("FAIL itype_state[%0d] got=%0d exp=%0d", i, state, exp_i[i]);
            end
            cyc();
        end
        bus.opcode = 7'b1101111;
        bus.zero = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_j[i]) begin
                errors++;
                $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, state, exp_j[i]);
            end
            if (i == 2) begin
                checks++;
                if ({bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB} !== 5'b10110) begin
                    errors++;
                    $display("FAIL jal_outputs got=%b exp=10110",
                        {bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB});
                end
            end
            cyc();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jal_end got=%0d exp=0", state);
        end
    endtask

    task automatic test_immsrc();
        logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110011};
        logic [1:0] imm [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 5; i++) begin
            bus.opcode = ops[i];
            #1;
            checks++;
            if (bus.ImmSrc !== imm[i]) begin
                errors++;
                $display("FAIL immsrc op=%b got=%b exp=%b", ops[i], bus.ImmSrc, imm[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.opcode = 7'b0100011;
        bus.mem_ready = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
        checks++;
        if ({state, bus.MemWrite} !== 5'b01011) begin
            errors++;
            $display("FAIL rstmid_pre got=%b exp=01011", {state, bus.MemWrite});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.MemWrite, bus.RegWrite, bus.PCWrite} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_enables got=%b exp=000",
                {bus.MemWrite, bus.RegWrite, bus.PCWrite});
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_state got=%0d exp=0", state);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sw_wait();
        int mw = 0;
        bus.opcode = 7'b0100011;
        bus.mem_ready = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== 4'd5) begin
                errors++;
                $display("FAIL sw_hold[%0d] got=%0d exp=5", i, state);
            end
            if (bus.MemWrite === 1'b1) mw++;
            cyc();
        end
        checks++;
        if (mw != 4) begin
            errors++;
            $display("FAIL sw_memwrite_cycles got=%0d exp=4", mw);
        end
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, bus.IRWrite, bus.PCWrite} !== 6'b000000) begin
            errors++;
            $display("FAIL fetch_stall got=%b exp=000000", {state, bus.IRWrite, bus.PCWrite});
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL fetch_hold got=%0d exp=0", state);
        end
        bus.mem_ready = 1'b1;
        #1;
`else
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, bus.MemWrite} !== 5'b01011) begin
            errors++;
            $display("FAIL sw_nowait got=%b exp=01011", {state, bus.MemWrite});
        end
        if (bus.MemWrite === 1'b1) mw++;
        cyc();
        checks++;
        if (state !== 4'd0 || mw != 1) begin
            errors++;
            $display("FAIL sw_end got=%0d mw=%0d exp=0 1", state, mw);
        end
        #1;
        checks++;
        if (bus.IRWrite !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ignores_ready got=%b exp=1", bus.IRWrite);
        end
        bus.mem_ready = 1'b1;
        #1;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rtype();
        test_lw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_itype_jal();
        test_immsrc();
        test_reset_mid();
        test_sw_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

- Main control state machine for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit `ALUop` to the ALU-control decoder: 00 add, 01 subtract, 10 decode funct3/funct7.
- Drives every datapath mux select and write enable.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

## Interface
Parameters:
- `STATE_W`, 4, width of the exported state code.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: instruction-register bits [6:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completion; used only with `MEM_WAIT_EN`.
- `ALUop` out 2: to ALU-control decoder.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ImmSrc` out 2: decoded from `opcode`. I 00, S 01, B 10, J 11, others 00.
- `AdrSrc` out 1: 0 PC, 1 Result.
- `IRWrite`, `RegWrite`, `MemWrite`, `PCWrite` out 1 each: enables.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out `STATE_W`: current state code, for debug.

## Operation
State codes and Moore outputs (unlisted outputs are 0):
- FETCH(0): AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUop=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUop=00 (branch target). Next by opcode:
  - 0000011 and 0100011: MEMADR.
  - 0110011: EXECUTER.
  - 0010011: EXECUTEI.
  - 1100011: BEQ.
  - 1101111: JAL.
  - Any other opcode: FETCH, with `illegal`=1 for that cycle.
- MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUop=00. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD(3): ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB(4): ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE(5): ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECUTER(6): ALUSrcA=10, ALUSrcB=00, ALUop=10. Next: ALUWB.
- EXECUTEI(7): ALUSrcA=10, ALUSrcB=01, ALUop=10. Next: ALUWB.
- ALUWB(8): ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ(9): ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL(10): ALUSrcA=01, ALUSrcB=10, ALUop=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Codes 11-15: treated as FETCH on the next edge. All enables 0 while in those codes.

Output rules:
- `PCWrite` = PCUpdate | (Branch & zero). This term is combinational from `zero`.
- `ImmSrc` is purely combinational from `opcode` and independent of state.

## Timing
- Reset: `rst_n` low at a rising edge forces state to FETCH.
- While `rst_n` is low, all enables (IRWrite, RegWrite, MemWrite, PCWrite, illegal) are held 0 combinationally. Selects take FETCH values.
- Reset asserted mid-instruction abandons it; no write enable fires in that cycle.
- Cycle counts without wait states:
  - lw: 5.
  - sw: 4.
  - R-type and I-type: 4.
  - beq: 3.
  - jal: 4.
  - illegal opcode: 2.
- `opcode` is sampled only in DECODE and MEMADR. IR changes outside those states have no effect.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE hold while `mem_ready`=0.
  - In FETCH, IRWrite and PCWrite are asserted only in the cycle `mem_ready`=1.
  - MemWrite stays high in MEMWRITE until `mem_ready`=1. The FSM advances on the edge where `mem_ready`=1.
- `MEM_WAIT_EN` undefined: `mem_ready` is ignored, memory is single-cycle, and the cycle counts in Timing apply.

## Test plan
- Reset, then release; opcode=0110011 for 4 cycles.
  - State sequence: 0,1,6,8.
  - ALUop=10 in state 6.
  - RegWrite=1 only in state 8.
- lw (0000011).
  - State sequence: 0,1,2,3,4.
  - AdrSrc=1 in state 3.
  - ResultSrc=01 and RegWrite=1 in state 4.
- beq (1100011), run twice.
  - With zero=1 in state 9: PCWrite=1 and ALUop=01.
  - With zero=0: PCWrite=0.
  - Both runs return to FETCH next.
- Opcode 1111111.
  - State sequence: 0,1,0.
  - `illegal` pulses exactly once, in DECODE.
  - No RegWrite or MemWrite.
- Assert `rst_n`=0 while in MEMWRITE.
  - MemWrite=0 in that cycle.
  - state=0 after the edge.
- With `MEM_WAIT_EN` defined, sw with `mem_ready` low for 3 cycles in MEMWRITE.
  - MemWrite held high for 4 cycles.
  - Returns to FETCH after `mem_ready`=1.
